// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU controller (optional MDU_FAST_MULT_EN)
module mdu_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opnd;     // mul: multiplicand magnitude; div: divisor magnitude
  logic        neg_res;  // product / quotient must be negated
  logic        neg_rem;  // remainder follows the dividend's sign

  // Operand decode and magnitudes, used when an op is accepted in IDLE
  logic        is_signed, is_div, sa, sb, div_zero, last;
  logic [31:0] abs_a, abs_b;
  assign is_signed = ~op[0];
  assign is_div    = op[1];
  assign sa        = is_signed & src_a[31];
  assign sb        = is_signed & src_b[31];
  assign abs_a     = sa ? (~src_a + 32'd1) : src_a;
  assign abs_b     = sb ? (~src_b + 32'd1) : src_b;
  assign div_zero  = is_div && (src_b == 32'd0);
  assign last      = (cnt == 6'd31);

  // One shift-add multiply step: add multiplicand if LSB set, shift right
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt, prod_fix;
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_nxt  = {mul_sum, acc[31:1]};
  assign prod_fix = neg_res ? (~mul_nxt + 64'd1) : mul_nxt;

  // One restoring divide step: shifted remainder is 33 bits, acc[63] is its MSB
  logic        div_ok;
  logic [31:0] div_rem, quo_fix, rem_fix;
  logic [63:0] div_nxt;
  assign div_ok  = acc[63] | (acc[62:31] >= opnd);
  assign div_rem = acc[62:31] - opnd;
  assign div_nxt = {div_ok ? div_rem : acc[62:31], acc[30:0], div_ok};
  assign quo_fix = neg_res ? (~div_nxt[31:0] + 32'd1) : div_nxt[31:0];
  assign rem_fix = neg_rem ? (~div_nxt[63:32] + 32'd1) : div_nxt[63:32];

`ifdef MDU_FAST_MULT_EN
  // Single-cycle product from the magnitudes, sign applied afterwards
  logic [63:0] fast_raw, fast_prod;
  assign fast_raw  = {32'd0, abs_a} * {32'd0, abs_b};
  assign fast_prod = (sa ^ sb) ? (~fast_raw + 64'd1) : fast_raw;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and stall/done decode; flush overrides everything
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          stall = 1'b1;
          if (div_zero)    state_nxt = S_DONE;
          else if (is_div) state_nxt = S_DIV;
          else begin
`ifdef MDU_FAST_MULT_EN
            state_nxt = S_DONE;
`else
            state_nxt = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        stall = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DIV: begin
        stall = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
      stall     = 1'b0;
      done      = 1'b0;
    end
  end

  // Datapath: operand latch, iteration, and result write on entry to DONE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= 6'd0;
      acc     <= 64'd0;
      opnd    <= 32'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (flush) begin
      cnt <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt     <= 6'd0;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            if (is_div) begin
              acc  <= {32'd0, abs_a};
              opnd <= abs_b;
              if (div_zero) begin
                hi <= src_a;
                lo <= 32'hFFFF_FFFF;
              end
            end else begin
              acc  <= {32'd0, abs_b};
              opnd <= abs_a;
`ifdef MDU_FAST_MULT_EN
              {hi, lo} <= fast_prod;
`endif
            end
          end
        end
        S_MUL: begin
          acc <= mul_nxt;
          cnt <= cnt + 6'd1;
          if (last) {hi, lo} <= prod_fix;
        end
        S_DIV: begin
          acc <= div_nxt;
          cnt <= cnt + 6'd1;
          if (last) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: cnt <= 6'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl against an arithmetic reference model
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stall, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_hi = 32'd0, last_lo = 32'd0;

  mdu_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'd0: r = sa * sb;
      2'd1: r = ua * ub;
      default: begin
        if (b == 32'd0)  r = {a, 32'hFFFF_FFFF};
        else if (o == 2'd2) r = {32'(sa % sb), 32'(sa / sb)};
        else                r = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return r;
  endfunction

  function automatic int ref_done_cycle(input logic [1:0] o, input logic [31:0] b);
    if (o[1] && b == 32'd0) return 1;
`ifdef MDU_FAST_MULT_EN
    if (!o[1]) return 1;
`endif
    return 33;
  endfunction

  // Issue one op, hold start while stalled, check timing and result
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    bit got_done, stall_gap;
    logic [63:0] exp;
    exp = ref_result(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 check({tag, "_stall_c0"}, {63'd0, stall}, 64'd1);
    cyc = 0; got_done = 0; stall_gap = 0;
    while (!got_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) got_done = 1;
      else if (!stall) stall_gap = 1;
    end
    check({tag, "_done_seen"}, {63'd0, got_done}, 64'd1);
    check({tag, "_done_cycle"}, 64'(cyc), 64'(ref_done_cycle(o, b)));
    check({tag, "_stall_gap"}, {63'd0, stall_gap}, 64'd0);
    check({tag, "_stall_done"}, {63'd0, stall}, 64'd0);
    check({tag, "_hilo"}, {hi, lo}, exp);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, {62'd0, done, stall}, 64'd0);
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {30'd0, stall, done, hi, lo}, 64'd0);
    resetn = 1'b1;

    // Directed cases
    run_op("div_7_m2",   2'd2, 32'd7, 32'hFFFF_FFFE);
    check("div_7_m2_lit", {last_hi, last_lo}, {32'h1, 32'hFFFF_FFFD});
    run_op("multu_max",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_lit", {last_hi, last_lo}, {32'hFFFF_FFFE, 32'h1});
    run_op("mult_m1",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mult_m1_lit", {last_hi, last_lo}, 64'd1);
    run_op("divu_zero",  2'd3, 32'h1234_5678, 32'd0);
    run_op("div_zero_n", 2'd2, 32'h8000_0001, 32'd0);
    run_op("div_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_neg_a",  2'd2, 32'hFFFF_FF9C, 32'd7);
    run_op("divu_big",   2'd3, 32'hFFFF_FFFF, 32'h8000_0001);

    // Flush in cycle 10 of a DIV: no done, results untouched
    begin
      int cyc;
      bit seen;
      @(negedge clk);
      start = 1'b1; op = 2'd2; src_a = 32'd1000; src_b = 32'd3;
      repeat (10) @(negedge clk);
      flush = 1'b1; start = 1'b0;
      #1 check("flush_stall", {62'd0, stall, done}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      seen = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk);
        if (done || stall) seen = 1;
      end
      check("flush_no_done", {63'd0, seen}, 64'd0);
      check("flush_hilo", {hi, lo}, {last_hi, last_lo});
    end
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7);
    check("divu_100_7_lit", {last_hi, last_lo}, {32'd2, 32'd14});

    // start together with flush in IDLE is ignored
    begin
      bit seen;
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'd3; src_a = 32'd50; src_b = 32'd5;
      #1 check("startflush_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || stall) seen = 1;
      end
      check("startflush_idle", {63'd0, seen}, 64'd0);
      check("startflush_hilo", {hi, lo}, {last_hi, last_lo});
    end

    // Randomized ops
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    // Reset in cycle 5 of a DIV: outputs clear immediately, block stays idle
    begin
      bit seen;
      @(negedge clk);
      start = 1'b1; op = 2'd2; src_a = 32'd12345; src_b = 32'd11;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1 check("reset_mid", {30'd0, stall, done, hi, lo}, 64'd0);
      start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || stall) seen = 1;
      end
      check("reset_idle", {63'd0, seen}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
    end
    run_op("post_reset", 2'd0, 32'hFFFF_FFF9, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
